// File: rtl/ball_physics.sv
`default_nettype none
// ============================================================================
// Module   : ball_physics
// Purpose  : Single-ball frame-update engine. Once per frame (in blanking) a
//            small FSM applies button/tilt acceleration with speed clamping,
//            periodic friction, movement and wall bounce. A 3-stage pipeline
//            renders the ball as a filled circle over the background.
// Ports    : pixel_clk, rst_n (sync, active-low)
//            button_c (recentre), button_u/d/l/r (accelerate -y/+y/-x/+x)
//            accel_x/accel_y (signed tilt, used only with the tilt option)
//            h_coord/v_coord (current pixel) -> red/green/blue (3-cycle lag)
//            ball_x/ball_y (ball centre), bounce (1-cycle wall-hit pulse)
// Option   : BALL_PHYSICS_ACCEL_TILT_EN adds (accel >>> 4) to the velocity
//            during ACCEL; when undefined the tilt inputs are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module ball_physics #(
  parameter int          H_ACTIVE        = 800,
  parameter int          V_ACTIVE        = 600,
  parameter int          RADIUS          = 10,
  parameter int          VEL_W           = 6,
  parameter int          MAX_SPEED       = 15,
  parameter int          ACCEL_STEP      = 1,
  parameter int          FRICTION_FRAMES = 5,
  parameter int          DECEL           = 1,
  parameter logic [11:0] BALL_COLOR      = 12'hFFF,
  parameter logic [11:0] BG_COLOR        = 12'h000
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       button_c,
  input  logic       button_u,
  input  logic       button_d,
  input  logic       button_l,
  input  logic       button_r,
  input  logic [7:0] accel_x,
  input  logic [7:0] accel_y,
  input  logic [9:0] h_coord,
  input  logic [9:0] v_coord,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       bounce
);

  // Velocity arithmetic is carried two bits wider than storage so that the
  // sum of step, tilt and current velocity never wraps before saturation.
  localparam int AW = VEL_W + 2;
  localparam int FW = (FRICTION_FRAMES > 1) ? $clog2(FRICTION_FRAMES) : 1;

  localparam logic [9:0]             c_h_last    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]             c_v_last    = 10'(V_ACTIVE - 1);
  localparam logic [9:0]             c_cx        = 10'(H_ACTIVE / 2);
  localparam logic [9:0]             c_cy        = 10'(V_ACTIVE / 2);
  localparam logic signed [11:0]     c_lo        = 12'(RADIUS);
  localparam logic signed [11:0]     c_x_hi      = 12'(H_ACTIVE - 1 - RADIUS);
  localparam logic signed [11:0]     c_y_hi      = 12'(V_ACTIVE - 1 - RADIUS);
  localparam logic signed [AW-1:0]   c_vmax      = AW'(MAX_SPEED);
  localparam logic signed [AW-1:0]   c_step      = AW'(ACCEL_STEP);
  localparam logic signed [AW-1:0]   c_decel     = AW'(DECEL);
  localparam logic [FW-1:0]          c_fric_last = FW'(FRICTION_FRAMES - 1);
  localparam logic [21:0]            c_r2        = 22'(RADIUS * RADIUS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCEL    = 3'd1,
    S_FRICTION = 3'd2,
    S_MOVE     = 3'd3,
    S_BOUNCE   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_frame_tick;
  logic                      r_recentre;
  logic                      r_skip;       // recentre frame: later states hold
  logic [FW-1:0]             r_fric_cnt;
  logic signed [VEL_W-1:0]   r_vx;
  logic signed [VEL_W-1:0]   r_vy;
  logic signed [11:0]        r_nx;
  logic signed [11:0]        r_ny;
  logic signed [10:0]        r_dx;
  logic signed [10:0]        r_dy;
  logic                      r_inside;

  logic signed [AW-1:0]      w_tilt_x;
  logic signed [AW-1:0]      w_tilt_y;
  logic signed [AW-1:0]      w_vx_acc;
  logic signed [AW-1:0]      w_vy_acc;
  logic signed [VEL_W-1:0]   w_abs_vx;
  logic signed [VEL_W-1:0]   w_abs_vy;
  logic                      w_hit_xl, w_hit_xh, w_hit_yl, w_hit_yh;
  logic signed [21:0]        w_dx_ext, w_dy_ext, w_dx2, w_dy2;
  logic [21:0]               w_d2;

  function automatic logic signed [AW-1:0] f_ext(input logic signed [VEL_W-1:0] v);
    return {{2{v[VEL_W-1]}}, v};
  endfunction

  function automatic logic signed [AW-1:0] f_step(input logic neg, input logic pos);
    if (neg && !pos) return -c_step;
    if (pos && !neg) return c_step;
    return '0;
  endfunction

  function automatic logic signed [VEL_W-1:0] f_sat(input logic signed [AW-1:0] v);
    if (v > c_vmax)  return VEL_W'(c_vmax);
    if (v < -c_vmax) return VEL_W'(-c_vmax);
    return VEL_W'(v);
  endfunction

  // Move toward zero by DECEL; anything within DECEL of zero lands on zero,
  // so the sign can never flip.
  function automatic logic signed [VEL_W-1:0] f_fric(input logic signed [AW-1:0] v);
    if (v > c_decel)  return VEL_W'(v - c_decel);
    if (v < -c_decel) return VEL_W'(v + c_decel);
    return '0;
  endfunction

`ifdef BALL_PHYSICS_ACCEL_TILT_EN
  // accel >>> 4 keeps only the top nibble, sign-extended.
  assign w_tilt_x = {{(AW-4){accel_x[7]}}, accel_x[7:4]};
  assign w_tilt_y = {{(AW-4){accel_y[7]}}, accel_y[7:4]};
`else
  logic w_unused_tilt;
  assign w_unused_tilt = ^{accel_x, accel_y};
  assign w_tilt_x = '0;
  assign w_tilt_y = '0;
`endif

  assign w_vx_acc = f_ext(r_vx) + f_step(button_l, button_r) + w_tilt_x;
  assign w_vy_acc = f_ext(r_vy) + f_step(button_u, button_d) + w_tilt_y;

  assign w_abs_vx = r_vx[VEL_W-1] ? -r_vx : r_vx;
  assign w_abs_vy = r_vy[VEL_W-1] ? -r_vy : r_vy;
  assign w_hit_xl = (r_nx < c_lo);
  assign w_hit_xh = (r_nx > c_x_hi);
  assign w_hit_yl = (r_ny < c_lo);
  assign w_hit_yh = (r_ny > c_y_hi);

  // State register
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: one cycle per update state; ticks outside IDLE are dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (r_frame_tick) w_state_nxt = S_ACCEL;
      S_ACCEL:    w_state_nxt = S_FRICTION;
      S_FRICTION: w_state_nxt = S_MOVE;
      S_MOVE:     w_state_nxt = S_BOUNCE;
      S_BOUNCE:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Physics datapath
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
      r_recentre   <= 1'b0;
      r_skip       <= 1'b0;
      r_fric_cnt   <= '0;
      r_vx         <= '0;
      r_vy         <= '0;
      r_nx         <= '0;
      r_ny         <= '0;
      ball_x       <= c_cx;
      ball_y       <= c_cy;
      bounce       <= 1'b0;
    end else begin
      r_frame_tick <= (h_coord == c_h_last) && (v_coord == c_v_last);
      r_recentre   <= r_recentre | button_c;
      bounce       <= 1'b0;
      case (r_state)
        S_ACCEL: begin
          if (r_recentre) begin
            ball_x     <= c_cx;
            ball_y     <= c_cy;
            r_vx       <= '0;
            r_vy       <= '0;
            r_recentre <= button_c;
            r_skip     <= 1'b1;
          end else begin
            r_vx   <= f_sat(w_vx_acc);
            r_vy   <= f_sat(w_vy_acc);
            r_skip <= 1'b0;
          end
        end
        S_FRICTION: begin
          if (!r_skip) begin
            if (r_fric_cnt == c_fric_last) begin
              r_fric_cnt <= '0;
              r_vx       <= f_fric(f_ext(r_vx));
              r_vy       <= f_fric(f_ext(r_vy));
            end else begin
              r_fric_cnt <= r_fric_cnt + 1'b1;
            end
          end
        end
        S_MOVE: begin
          if (!r_skip) begin
            r_nx <= $signed({2'b00, ball_x}) + $signed({{(12-VEL_W){r_vx[VEL_W-1]}}, r_vx});
            r_ny <= $signed({2'b00, ball_y}) + $signed({{(12-VEL_W){r_vy[VEL_W-1]}}, r_vy});
          end
        end
        S_BOUNCE: begin
          if (!r_skip) begin
            if (w_hit_xl) begin
              ball_x <= c_lo[9:0];
              r_vx   <= w_abs_vx;
            end else if (w_hit_xh) begin
              ball_x <= c_x_hi[9:0];
              r_vx   <= -w_abs_vx;
            end else begin
              ball_x <= r_nx[9:0];
            end
            if (w_hit_yl) begin
              ball_y <= c_lo[9:0];
              r_vy   <= w_abs_vy;
            end else if (w_hit_yh) begin
              ball_y <= c_y_hi[9:0];
              r_vy   <= -w_abs_vy;
            end else begin
              ball_y <= r_ny[9:0];
            end
            bounce <= w_hit_xl | w_hit_xh | w_hit_yl | w_hit_yh;
          end
        end
        default: ;
      endcase
    end
  end

  // Render: distances are taken with a zero-extended 11-bit signed subtract,
  // so pixels far from the ball never alias back into the circle.
  assign w_dx_ext = {{11{r_dx[10]}}, r_dx};
  assign w_dy_ext = {{11{r_dy[10]}}, r_dy};
  assign w_dx2    = w_dx_ext * w_dx_ext;
  assign w_dy2    = w_dy_ext * w_dy_ext;
  assign w_d2     = w_dx2 + w_dy2;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_dx               <= '0;
      r_dy               <= '0;
      r_inside           <= 1'b0;
      {red, green, blue} <= 12'h000;
    end else begin
      r_dx               <= $signed({1'b0, h_coord}) - $signed({1'b0, ball_x});
      r_dy               <= $signed({1'b0, v_coord}) - $signed({1'b0, ball_y});
      r_inside           <= (w_d2 <= c_r2);
      {red, green, blue} <= r_inside ? BALL_COLOR : BG_COLOR;
    end
  end

endmodule
`default_nettype wire
